ravan_cipher_core: RTL and testbench

Parametrised iterative RAVAN round engine; supersedes the fixed 64-bit decrypt-only path.
- Encrypts or decrypts one block per transaction, selected per transaction.
- Uses valid/ready handshakes, a latched key and tweak, and a per-block LFSR whitening mask.
- Sits between the key-slicing front end and the stream framer.
- Executes one full round per clock, so latency is deterministic.

---
 rtl/ravan_pkg.sv | 22 ++
 rtl/ravan_round.sv | 32 +++
 rtl/ravan_cipher_core.sv | 125 ++++++++++++
 tb/tb_ravan_cipher_core.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ravan_pkg.sv
// Shared constants and helpers for the RAVAN round engine.
// Mode encoding, FSM state codes, default whitening seed and the mask LFSR step.
package ravan_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic [63:0] MASK_SEED_DEFAULT = 64'hffda_1234_daae_a339;

  // Shift left by one, feeding back bit w-1 xor bit w-3; bits at or above w are don't-care.
  function automatic logic [63:0] lfsr_next(input logic [63:0] m, input int unsigned w);
    logic [63:0] fb;
    fb = ((m >> (w - 1)) ^ (m >> (w - 3))) & 64'd1;
    return (m << 1) | fb;
  endfunction

endpackage

// File: rtl/ravan_round.sv
// One full RAVAN round: all key slices applied in a single combinational pass.
// Decrypt walks the slices in reverse and undoes each encrypt step exactly.
module ravan_round
  import ravan_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SLICES = 8
) (
  input  logic [DATA_W-1:0]        x,
  input  logic [DATA_W*SLICES-1:0] key,
  input  logic [DATA_W-1:0]        tweak,
  input  logic                     mode,
  output logic [DATA_W-1:0]        x_next
);

  logic [DATA_W-1:0] acc;

  always_comb begin
    acc = x;
    if (mode == MODE_ENC) begin
      for (int j = 0; j < SLICES; j++) begin
        acc = ~(acc ^ key[j*DATA_W +: DATA_W]) + tweak;
      end
    end else begin
      for (int j = SLICES - 1; j >= 0; j--) begin
        acc = ~(acc - tweak) ^ key[j*DATA_W +: DATA_W];
      end
    end
    x_next = acc;
  end

endmodule

// File: rtl/ravan_cipher_core.sv
// Iterative RAVAN engine: one block per transaction, one round per clock,
// whitened with a per-block LFSR mask that advances on every accept.
module ravan_cipher_core
  import ravan_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          SLICES    = 8,
  parameter int          ROUNDS    = 21,
  parameter logic [63:0] MASK_SEED = MASK_SEED_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [DATA_W-1:0]        in_tweak,
  input  logic [DATA_W*SLICES-1:0] in_key,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy
);

  localparam int CNT_W = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUNDS - 1);
  localparam logic [DATA_W-1:0] SEED = MASK_SEED[DATA_W-1:0];

  state_t                     state_q, state_d;
  logic                       mode_q, mode_d;
  logic [DATA_W*SLICES-1:0]   key_q, key_d;
  logic [DATA_W-1:0]          tweak_q, tweak_d;
  logic [DATA_W-1:0]          x_q, x_d;
  logic [DATA_W-1:0]          m_used_q, m_used_d;
  logic [DATA_W-1:0]          mask_q, mask_d;
  logic [DATA_W-1:0]          out_data_q, out_data_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DATA_W-1:0]          x_next;
  logic [63:0]                mask_ext, mask_adv;

  ravan_round #(
    .DATA_W (DATA_W),
    .SLICES (SLICES)
  ) u_round (
    .x      (x_q),
    .key    (key_q),
    .tweak  (tweak_q),
    .mode   (mode_q),
    .x_next (x_next)
  );

  always_comb begin
    mask_ext = '0;
    mask_ext[DATA_W-1:0] = mask_q;
    mask_adv = lfsr_next(mask_ext, DATA_W);
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    key_d      = key_q;
    tweak_d    = tweak_q;
    x_d        = x_q;
    m_used_d   = m_used_q;
    mask_d     = mask_q;
    out_data_d = out_data_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d   = in_mode;
          key_d    = in_key;
          tweak_d  = in_tweak;
          x_d      = in_data ^ mask_q;
          m_used_d = mask_q;
          mask_d   = mask_adv[DATA_W-1:0];
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        x_d   = x_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          out_data_d = x_next ^ m_used_q;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ENC;
      key_q      <= '0;
      tweak_q    <= '0;
      x_q        <= '0;
      m_used_q   <= '0;
      mask_q     <= SEED;
      out_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      key_q      <= key_d;
      tweak_q    <= tweak_d;
      x_q        <= x_d;
      m_used_q   <= m_used_d;
      mask_q     <= mask_d;
      out_data_q <= out_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_ravan_cipher_core.sv
// Bench for ravan_cipher_core: small 1/2-round engines, an encrypt/decrypt pair
// at default parameters, and a scoreboard of expected outputs.
module tb_ravan_cipher_core;

  localparam logic [63:0] SEED = 64'hffda_1234_daae_a339;
  localparam int NR = 21;
  localparam int NS = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [63:0] q_main[$];
  logic [63:0] q_dec[$];
  logic [63:0] q_s1[$];
  logic [63:0] q_s2[$];
  logic [63:0] mask_e, mask_d;

  logic         e_rst, e_in_valid, e_in_ready, e_in_mode, e_out_valid, e_out_ready, e_busy;
  logic [63:0]  e_in_data, e_in_tweak, e_out_data;
  logic [511:0] e_in_key;
  logic         d_rst, d_in_valid, d_in_ready, d_in_mode, d_out_valid, d_out_ready, d_busy;
  logic [63:0]  d_in_data, d_in_tweak, d_out_data;
  logic [511:0] d_in_key;
  logic         s_rst, s_in_valid, s_in_mode, s_out_ready;
  logic [63:0]  s_in_data, s_in_tweak, s_in_key;
  logic         s1_in_ready, s1_out_valid, s1_busy, s2_in_ready, s2_out_valid, s2_busy;
  logic [63:0]  s1_out_data, s2_out_data;

  ravan_cipher_core dut (
    .clk(clk), .rst(e_rst), .in_valid(e_in_valid), .in_ready(e_in_ready),
    .in_mode(e_in_mode), .in_data(e_in_data), .in_tweak(e_in_tweak), .in_key(e_in_key),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data), .busy(e_busy)
  );

  ravan_cipher_core dut_dec (
    .clk(clk), .rst(d_rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_mode(d_in_mode), .in_data(d_in_data), .in_tweak(d_in_tweak), .in_key(d_in_key),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .busy(d_busy)
  );

  ravan_cipher_core #(.ROUNDS(1), .SLICES(1)) dut_r1 (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s1_in_ready),
    .in_mode(s_in_mode), .in_data(s_in_data), .in_tweak(s_in_tweak), .in_key(s_in_key),
    .out_valid(s1_out_valid), .out_ready(s_out_ready), .out_data(s1_out_data), .busy(s1_busy)
  );

  ravan_cipher_core #(.ROUNDS(2), .SLICES(1)) dut_r2 (
    .clk(clk), .rst(s_rst), .in_valid(s_in_valid), .in_ready(s2_in_ready),
    .in_mode(s_in_mode), .in_data(s_in_data), .in_tweak(s_in_tweak), .in_key(s_in_key),
    .out_valid(s2_out_valid), .out_ready(s_out_ready), .out_data(s2_out_data), .busy(s2_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_block(input logic [63:0] d, input logic [511:0] key,
                                          input logic [63:0] tw, input logic dec,
                                          input logic [63:0] mask, input int rounds,
                                          input int slices);
    logic [63:0] x;
    x = d ^ mask;
    for (int r = 0; r < rounds; r++) begin
      if (!dec) for (int j = 0; j < slices; j++) x = ~(x ^ key[j*64 +: 64]) + tw;
      else      for (int j = slices - 1; j >= 0; j--) x = ~(x - tw) ^ key[j*64 +: 64];
    end
    return x ^ mask;
  endfunction

  function automatic logic [63:0] m_adv(input logic [63:0] m);
    return {m[62:0], m[63] ^ m[61]};
  endfunction

  function automatic logic [511:0] rand_key();
    logic [511:0] k;
    for (int i = 0; i < 16; i++) k[i*32 +: 32] = $urandom();
    return k;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic e_start(input logic [63:0] dat, input logic [63:0] tw, input logic [511:0] key);
    @(negedge clk);
    check("e_in_ready_idle", 64'(e_in_ready), 64'd1);
    e_in_valid = 1'b1; e_in_mode = 1'b0; e_in_data = dat; e_in_tweak = tw; e_in_key = key;
    q_main.push_back(m_block(dat, key, tw, 1'b0, mask_e, NR, NS));
    mask_e = m_adv(mask_e);
    @(negedge clk);
    e_in_valid = 1'b0;
    e_in_data  = rand64();
  endtask

  task automatic e_wait(input logic scramble, output int lat);
    lat = 0;
    while (!e_out_valid && lat < 200) begin
      if (scramble) begin
        e_in_key   = rand_key();
        e_in_tweak = rand64();
      end
      @(negedge clk);
      lat++;
    end
    check("e_latency", 64'(lat), 64'(NR));
  endtask

  task automatic e_take(input string tag);
    logic [63:0] exp;
    exp = (q_main.size() > 0) ? q_main.pop_front() : 64'hx;
    check(tag, e_out_data, exp);
    e_out_ready = 1'b1;
    @(negedge clk);
    e_out_ready = 1'b0;
    check("e_valid_drop", 64'(e_out_valid), 64'd0);
    check("e_ready_back", 64'(e_in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    logic [63:0] dat, tw, ct, exp;
    logic [511:0] key;

    mask_e = SEED; mask_d = SEED;
    e_rst = 1; d_rst = 1; s_rst = 1;
    e_in_valid = 0; e_in_mode = 0; e_in_data = 0; e_in_tweak = 0; e_in_key = '0; e_out_ready = 0;
    d_in_valid = 0; d_in_mode = 1; d_in_data = 0; d_in_tweak = 0; d_in_key = '0; d_out_ready = 0;
    s_in_valid = 0; s_in_mode = 0; s_in_data = 0; s_in_tweak = 0; s_in_key = 0; s_out_ready = 1;
    repeat (3) @(negedge clk);
    e_rst = 0; d_rst = 0; s_rst = 0;

    check("rst_in_ready", 64'(e_in_ready), 64'd1);
    check("rst_out_valid", 64'(e_out_valid), 64'd0);
    check("rst_out_data", e_out_data, 64'd0);
    check("rst_busy", 64'(e_busy), 64'd0);

    // 1-round and 2-round engines, two blocks each
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      s_in_valid = 1;
      s_in_data  = (b == 0) ? 64'h0123456789ABCDEF : 64'd0;
      q_s1.push_back((b == 0) ? 64'hFEDCBA9876543210 : 64'hFFFFFFFFFFFFFFFF);
      q_s2.push_back((b == 0) ? 64'h0123456789ABCDEF : 64'd0);
      @(negedge clk);
      s_in_valid = 0;
      check("s1_not_valid_lat0", 64'(s1_out_valid), 64'd0);
      check("s1_busy_lat0", 64'(s1_busy), 64'd1);
      @(negedge clk);
      check("s1_valid_lat1", 64'(s1_out_valid), 64'd1);
      exp = (q_s1.size() > 0) ? q_s1.pop_front() : 64'hx;
      check("s1_data", s1_out_data, exp);
      check("s2_not_valid_lat1", 64'(s2_out_valid), 64'd0);
      @(negedge clk);
      check("s2_valid_lat2", 64'(s2_out_valid), 64'd1);
      exp = (q_s2.size() > 0) ? q_s2.pop_front() : 64'hx;
      check("s2_data", s2_out_data, exp);
      check("s1_consumed", 64'(s1_out_valid), 64'd0);
      @(negedge clk);
    end

    // encrypt -> decrypt round trip at default parameters
    for (int n = 0; n < 100; n++) begin
      dat = rand64(); tw = rand64(); key = rand_key();
      e_start(dat, tw, key);
      e_wait(1'b0, lat);
      ct = e_out_data;
      e_take("t3_enc_data");
      @(negedge clk);
      d_in_valid = 1; d_in_mode = 1; d_in_data = ct; d_in_tweak = tw; d_in_key = key;
      q_dec.push_back(dat);
      mask_d = m_adv(mask_d);
      @(negedge clk);
      d_in_valid = 0;
      lat = 0;
      while (!d_out_valid && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      check("d_latency", 64'(lat), 64'(NR));
      exp = (q_dec.size() > 0) ? q_dec.pop_front() : 64'hx;
      check("t3_roundtrip", d_out_data, exp);
      d_out_ready = 1;
      @(negedge clk);
      d_out_ready = 0;
    end

    // back-pressure in DONE: output held, new blocks refused
    e_start(rand64(), rand64(), rand_key());
    e_wait(1'b0, lat);
    exp = (q_main.size() > 0) ? q_main[0] : 64'hx;
    for (int c = 0; c < 10; c++) begin
      e_in_valid = 1; e_in_data = rand64();
      @(negedge clk);
      check("t4_hold_data", e_out_data, exp);
      check("t4_hold_ready", 64'(e_in_ready), 64'd0);
      check("t4_hold_valid", 64'(e_out_valid), 64'd1);
    end
    e_in_valid = 0;
    e_take("t4_data");
    e_start(rand64(), rand64(), rand_key());
    e_wait(1'b0, lat);
    e_take("t4_after_data");

    // reset during RUN aborts the block and restores the mask seed
    e_start(rand64(), rand64(), rand_key());
    repeat (5) @(negedge clk);
    e_rst = 1;
    @(negedge clk);
    e_rst = 0;
    check("t5_out_valid", 64'(e_out_valid), 64'd0);
    check("t5_in_ready", 64'(e_in_ready), 64'd1);
    check("t5_busy", 64'(e_busy), 64'd0);
    q_main.delete();
    mask_e = SEED;
    repeat (25) @(negedge clk);
    check("t5_no_output", 64'(e_out_valid), 64'd0);
    e_start(rand64(), rand64(), rand_key());
    e_wait(1'b0, lat);
    e_take("t5_first_after_rst");

    // key/tweak churn during RUN must not matter
    for (int n = 0; n < 3; n++) begin
      e_start(rand64(), rand64(), rand_key());
      e_wait(1'b1, lat);
      e_take("t6_key_churn");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
